// File: rtl/ac_climate_ctrl_pkg.sv
// Shared definitions for the climate controller: mode codes, FSM states and
// the fan PWM duty table.
package ac_climate_ctrl_pkg;

  // Operating mode as supplied by the UI.
  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_COOL = 2'd1,
    MODE_DRY  = 2'd2,
    MODE_FAN  = 2'd3
  } mode_e;

  // Controller state. Encodings match the legacy state codes.
  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_FAN_ONLY = 2'd1,
    ST_IDLE     = 2'd2,
    ST_RUN      = 2'd3
  } state_e;

  // PWM duty thresholds per fan level (out of 256 counter steps).
  localparam logic [7:0] DUTY_L0 = 8'd0;
  localparam logic [7:0] DUTY_L1 = 8'd85;
  localparam logic [7:0] DUTY_L2 = 8'd170;
  localparam logic [7:0] DUTY_L3 = 8'd255;

  function automatic logic [7:0] duty_for_level(input logic [1:0] lvl);
    logic [7:0] duty;
    case (lvl)
      2'd0:    duty = DUTY_L0;
      2'd1:    duty = DUTY_L1;
      2'd2:    duty = DUTY_L2;
      default: duty = DUTY_L3;
    endcase
    return duty;
  endfunction

endpackage

// File: rtl/ac_climate_ctrl_sample_tick.sv
// Periodic sample strobe: one-cycle pulse every SAMPLE_CYC clocks, the first
// one SAMPLE_CYC clocks after reset is released.
module ac_sample_tick #(
  parameter int unsigned SAMPLE_CYC = 100_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned CW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Free-running period counter, wraps on the tick.
  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ac_climate_ctrl.sv
// Climate controller: samples DHT11 temperature/humidity, averages over a
// 4-deep window, runs COOL/DRY hysteresis control of the compressor with a
// min-on/min-off lockout, and drives the fan as a 4-level PWM.
module ac_climate_ctrl
  import ac_climate_ctrl_pkg::*;
#(
  parameter int unsigned SAMPLE_CYC = 100_000_000,
  parameter int unsigned LOCK_SMP   = 3,
  parameter logic [7:0]  HYST       = 8'd1,
  parameter logic [7:0]  HUM_ON     = 8'd60,
  parameter logic [7:0]  HUM_OFF    = 8'd50,
  parameter int unsigned PWM_DIV    = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] humidity,
  input  logic [7:0] current_temperature,
  input  logic [7:0] set_temp,
  input  logic [1:0] mode,
  input  logic [1:0] fan_manual,
  output logic       compressor_on,
  output logic       fan_pwm,
  output logic [1:0] fan_level,
  output logic [7:0] avg_temp,
  output logic [7:0] avg_humidity,
  output logic       sample_valid
);

  localparam int unsigned LW = (LOCK_SMP > 0) ? $clog2(LOCK_SMP + 1) : 1;
  localparam int unsigned PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [LW-1:0] LOCK_RELOAD = LW'(LOCK_SMP);
  localparam logic [PW-1:0] PRE_LAST    = PW'(PWM_DIV - 1);

  // ---------------------------------------------------------------- tick
  logic tick;

  ac_sample_tick #(
    .SAMPLE_CYC(SAMPLE_CYC)
  ) u_tick (
    .clk_i (clk),
    .rst_ni(reset),
    .tick_o(tick)
  );

  // -------------------------------------------------------------- window
  logic [3:0][7:0] temp_win_q, temp_win_d;
  logic [3:0][7:0] hum_win_q,  hum_win_d;
  logic            filled_q,   filled_d;
  logic [9:0]      temp_sum,   hum_sum;

  // Shift the new sample in on a tick; the first tick after reset preloads
  // every entry so the average is meaningful immediately.
  always_comb begin
    temp_win_d = temp_win_q;
    hum_win_d  = hum_win_q;
    filled_d   = filled_q;
    if (tick) begin
      filled_d = 1'b1;
      if (!filled_q) begin
        temp_win_d = {4{current_temperature}};
        hum_win_d  = {4{humidity}};
      end else begin
        temp_win_d = {temp_win_q[2:0], current_temperature};
        hum_win_d  = {hum_win_q[2:0], humidity};
      end
    end
  end

  // Window sums, 10 bits wide to hold four 8-bit samples.
  always_comb begin
    temp_sum = '0;
    hum_sum  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      temp_sum = temp_sum + 10'(temp_win_q[i]);
      hum_sum  = hum_sum + 10'(hum_win_q[i]);
    end
  end

  // Window storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      temp_win_q <= '0;
      hum_win_q  <= '0;
      filled_q   <= 1'b0;
    end else begin
      temp_win_q <= temp_win_d;
      hum_win_q  <= hum_win_d;
      filled_q   <= filled_d;
    end
  end

  // ------------------------------------------------------------- averages
  logic       tick_d1_q;
  logic [7:0] avg_temp_q, avg_hum_q;
  logic       valid_q;

  // Averages register one cycle after the tick that updated the window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_d1_q  <= 1'b0;
      avg_temp_q <= '0;
      avg_hum_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      tick_d1_q <= tick;
      valid_q   <= tick_d1_q;
      if (tick_d1_q) begin
        avg_temp_q <= temp_sum[9:2];
        avg_hum_q  <= hum_sum[9:2];
      end
    end
  end

  // ------------------------------------------------------------------ FSM
  mode_e         eff_mode;
  state_e        state_q, state_d;
  logic          comp_q,  comp_d;
  logic [LW-1:0] lock_q,  lock_d;
  logic          start_ok, stop_ok;
  logic [7:0]    cool_low;

  assign eff_mode = en ? mode_e'(mode) : MODE_OFF;
  assign cool_low = (set_temp >= HYST) ? (set_temp - HYST) : '0;

  // Start/stop thresholds for the active mode, evaluated on fresh averages.
  always_comb begin
    if (eff_mode == MODE_COOL) begin
      start_ok = ({1'b0, avg_temp_q} >= ({1'b0, set_temp} + {1'b0, HYST}));
      stop_ok  = (avg_temp_q <= cool_low);
    end else begin
      start_ok = (avg_hum_q >= HUM_ON);
      stop_ok  = (avg_hum_q <= HUM_OFF);
    end
  end

  // Mode/enable changes act every cycle; compressor start/stop only on the
  // cycle the new averages become visible and only once lockout has expired.
  always_comb begin
    state_d = state_q;
    case (eff_mode)
      MODE_OFF: state_d = ST_OFF;
      MODE_FAN: state_d = ST_FAN_ONLY;
      default: begin
        case (state_q)
          ST_IDLE: if (valid_q && lock_q == '0 && start_ok) state_d = ST_RUN;
          ST_RUN:  if (valid_q && lock_q == '0 && stop_ok)  state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    endcase
  end

  assign comp_d = (state_d == ST_RUN);

  // Lockout counts down on sample ticks; any compressor edge restarts it,
  // including a forced drop from a mode/enable change.
  always_comb begin
    lock_d = lock_q;
    if (tick && lock_q != '0) lock_d = lock_q - 1'b1;
    if (comp_d != comp_q)     lock_d = LOCK_RELOAD;
  end

  // FSM, compressor and lockout registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_OFF;
      comp_q  <= 1'b0;
      lock_q  <= LOCK_RELOAD;
    end else begin
      state_q <= state_d;
      comp_q  <= comp_d;
      lock_q  <= lock_d;
    end
  end

  // ------------------------------------------------------------ fan / PWM
  logic [1:0]    level_q, level_d;
  logic [PW-1:0] pre_q,   pre_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic          pwm_q,   pwm_d;
  logic          pre_step;

  // Fan level follows the next state so it changes together with the relay.
  always_comb begin
    level_d = 2'd0;
    case (state_d)
      ST_OFF:      level_d = 2'd0;
      ST_FAN_ONLY: level_d = fan_manual;
      ST_IDLE:     level_d = 2'd1;
      default: begin
        level_d = 2'd1;
        if (eff_mode == MODE_COOL) begin
          if ({2'b0, avg_temp_q} >= ({2'b0, set_temp} + 10'd4))      level_d = 2'd3;
          else if ({2'b0, avg_temp_q} >= ({2'b0, set_temp} + 10'd2)) level_d = 2'd2;
        end
      end
    endcase
  end

  assign pre_step = (pre_q == PRE_LAST);

  // PWM prescaler, counter and compare; level 3 is held solidly on.
  always_comb begin
    pre_d     = pre_step ? '0 : pre_q + 1'b1;
    pwm_cnt_d = pre_step ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    pwm_d     = (level_q == 2'd3) ? 1'b1 : (pwm_cnt_q < duty_for_level(level_q));
  end

  // Fan registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q   <= '0;
      pre_q     <= '0;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      level_q   <= level_d;
      pre_q     <= pre_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign compressor_on = comp_q;
  assign fan_level     = level_q;
  assign fan_pwm       = pwm_q;
  assign avg_temp      = avg_temp_q;
  assign avg_humidity  = avg_hum_q;
  assign sample_valid  = valid_q;

endmodule

// File: tb/tb_ac_climate_ctrl.sv
// Bench for ac_climate_ctrl: directed scenarios plus randomized segments,
// every output compared each cycle with a behavioural reference model.
module tb_ac_climate_ctrl;

  localparam int S = 10;
  localparam int L = 3;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] humidity;
  logic [7:0] current_temperature;
  logic [7:0] set_temp;
  logic [1:0] mode;
  logic [1:0] fan_manual;
  logic       compressor_on;
  logic       fan_pwm;
  logic [1:0] fan_level;
  logic [7:0] avg_temp;
  logic [7:0] avg_humidity;
  logic       sample_valid;

  int errors = 0;
  int checks = 0;

  ac_climate_ctrl #(
    .SAMPLE_CYC(S),
    .LOCK_SMP  (L),
    .HYST      (8'd1),
    .HUM_ON    (8'd60),
    .HUM_OFF   (8'd50),
    .PWM_DIV   (1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .en                 (en),
    .humidity           (humidity),
    .current_temperature(current_temperature),
    .set_temp           (set_temp),
    .mode               (mode),
    .fan_manual         (fan_manual),
    .compressor_on      (compressor_on),
    .fan_pwm            (fan_pwm),
    .fan_level          (fan_level),
    .avg_temp           (avg_temp),
    .avg_humidity       (avg_humidity),
    .sample_valid       (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  int m_cyc = 0;
  int tq[$];
  int hq[$];
  int m_avg_t = 0, m_avg_h = 0;
  bit m_valid = 0, m_tick_last = 0;
  int m_lock = L;
  bit m_comp = 0, m_active = 0, m_pwm = 0;
  int m_level = 0;

  task automatic model_reset();
    m_cyc = 0; tq.delete(); hq.delete();
    m_avg_t = 0; m_avg_h = 0; m_valid = 0; m_tick_last = 0;
    m_lock = L; m_comp = 0; m_active = 0; m_level = 0; m_pwm = 0;
  endtask

  task automatic model_step();
    int em, st, sum_t, sum_h, new_t, new_h, lvl, d;
    bit tick, eval, cmp, start, stop;
    em = en ? int'(mode) : 0;
    st = int'(set_temp);
    m_cyc++;
    tick = (m_cyc % S == 0);
    eval = m_valid;
    // averages become visible the clock after the sample tick
    new_t = m_avg_t; new_h = m_avg_h;
    if (m_tick_last) begin
      sum_t = 0; sum_h = 0;
      foreach (tq[i]) sum_t += tq[i];
      foreach (hq[i]) sum_h += hq[i];
      new_t = sum_t / 4; new_h = sum_h / 4;
    end
    // compressor decision on the freshly published averages
    cmp = 0;
    if (em == 1 || em == 2) begin
      start = (em == 1) ? (m_avg_t >= st + 1) : (m_avg_h >= 60);
      stop  = (em == 1) ? (m_avg_t <= ((st >= 1) ? st - 1 : 0)) : (m_avg_h <= 50);
      cmp = m_comp;
      if (!m_active) cmp = 0;
      else if (eval && m_lock == 0) begin
        if (!m_comp && start) cmp = 1;
        else if (m_comp && stop) cmp = 0;
      end
    end
    if (em == 0) lvl = 0;
    else if (em == 3) lvl = int'(fan_manual);
    else if (cmp && em == 1) begin
      d = m_avg_t - st;
      lvl = (d >= 4) ? 3 : (d >= 2) ? 2 : 1;
    end else lvl = 1;
    m_pwm = (m_level == 3) ? 1'b1 : (((m_cyc - 1) % 256) < m_level * 85);
    if (tick && m_lock > 0) m_lock--;
    if (cmp != m_comp) m_lock = L;
    if (tick) begin
      if (tq.size() == 0) begin
        repeat (4) begin tq.push_back(current_temperature); hq.push_back(humidity); end
      end else begin
        tq.push_back(current_temperature); void'(tq.pop_front());
        hq.push_back(humidity);            void'(hq.pop_front());
      end
    end
    m_avg_t = new_t; m_avg_h = new_h;
    m_valid = m_tick_last; m_tick_last = tick;
    m_comp = cmp; m_active = (em == 1 || em == 2); m_level = lvl;
  endtask

  always @(posedge clk) begin
    if (!reset) model_reset();
    else        model_step();
  end

  // ---------------------------------------------------------------- check
  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_all();
    check_eq("compressor_on", int'(compressor_on), int'(m_comp));
    check_eq("fan_level",     int'(fan_level),     m_level);
    check_eq("fan_pwm",       int'(fan_pwm),       int'(m_pwm));
    check_eq("avg_temp",      int'(avg_temp),      m_avg_t);
    check_eq("avg_humidity",  int'(avg_humidity),  m_avg_h);
    check_eq("sample_valid",  int'(sample_valid),  int'(m_valid));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_all();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run(5);
    reset = 1'b1;
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    int hi;
    reset = 1'b0; en = 1'b1; humidity = 8'd40; current_temperature = 8'd24;
    set_temp = 8'd24; mode = 2'd0; fan_manual = 2'd0;
    run(5);
    reset = 1'b1;

    // rising temperature ramp with preload
    mode = 2'd1; set_temp = 8'd30;
    run(S - 1); current_temperature = 8'd25;
    run(S);     current_temperature = 8'd26;
    run(S);     current_temperature = 8'd27;
    run(2 * S);

    // COOL from reset: hot room, then cool down
    do_reset();
    mode = 2'd1; set_temp = 8'd24; current_temperature = 8'd30;
    run(S * 3 + 1);
    check_eq("cool_not_yet", int'(compressor_on), 0);
    run(1);
    check_eq("cool_start_tick3", int'(compressor_on), 1);
    run(S * 2);
    current_temperature = 8'd23;
    run(S * 8);

    // DRY sequence
    mode = 2'd2; humidity = 8'd65; run(S * 8);
    humidity = 8'd55; run(S * 8);
    humidity = 8'd50; run(S * 8);

    // mode drop while running, then resume
    humidity = 8'd70; run(S * 8);
    check_eq("dry_running", int'(compressor_on), 1);
    mode = 2'd0; run(1);
    check_eq("drop_on_off", int'(compressor_on), 0);
    mode = 2'd2; run(S * 6);

    // reset asserted mid-run
    do_reset();
    mode = 2'd1; current_temperature = 8'd28; run(S * 6);

    // FAN mode duty measurement
    mode = 2'd3; fan_manual = 2'd2; run(4);
    hi = 0;
    repeat (256) begin @(negedge clk); cmp_all(); hi += int'(fan_pwm); end
    check_eq("fan2_duty", hi, 170);
    fan_manual = 2'd3; run(4);
    hi = 0;
    repeat (256) begin @(negedge clk); cmp_all(); hi += int'(fan_pwm); end
    check_eq("fan3_duty", hi, 256);

    // randomized segments
    for (int seg = 0; seg < 200; seg++) begin
      if ($urandom_range(0, 24) == 0) do_reset();
      en         = ($urandom_range(0, 9) != 0);
      mode       = 2'($urandom_range(0, 3));
      fan_manual = 2'($urandom_range(0, 3));
      set_temp   = 8'($urandom_range(0, 40));
      current_temperature = 8'($urandom_range(0, 10) + int'(set_temp) - 5 + 5);
      if ($urandom_range(0, 7) == 0) current_temperature = 8'($urandom_range(0, 255));
      humidity   = 8'($urandom_range(40, 75));
      run($urandom_range(5, 60));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
